score_display_driver: RTL and testbench



---
 rtl/score_display_driver.sv | 182 ++++++++++++++++++
 tb/tb_score_display_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// Multi-digit 7-segment driver for the HEX displays. Shows a binary value in hex or in decimal
// (serial shift-add-3 BCD conversion) with optional leading-zero blanking and an overflow indication.
module score_display_driver #(
    parameter int VALUE_W    = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    load,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] hex_segs,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [VALUE_W-1:0] shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sticky_q;
    logic               dec_mode_q;
    logic               blank_lz_q;

    logic [BCD_W-1:0]        adj_s;
    logic [BCD_W-1:0]        conv_bcd_s;
    logic                    conv_carry_s;
    logic [EXT_W-1:0]        ext_s;
    logic                    hex_ovf_s;
    logic [BCD_W-1:0]        digits_s;
    logic                    ovf_s;
    logic [7*NUM_DIGITS-1:0] segs_s;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b100_0000;
            4'h1:    seg = 7'b111_1001;
            4'h2:    seg = 7'b010_0100;
            4'h3:    seg = 7'b011_0000;
            4'h4:    seg = 7'b001_1001;
            4'h5:    seg = 7'b001_0010;
            4'h6:    seg = 7'b000_0010;
            4'h7:    seg = 7'b111_1000;
            4'h8:    seg = 7'b000_0000;
            4'h9:    seg = 7'b001_0000;
            4'hA:    seg = 7'b000_1000;
            4'hB:    seg = 7'b000_0011;
            4'hC:    seg = 7'b100_0110;
            4'hD:    seg = 7'b010_0001;
            4'hE:    seg = 7'b000_0110;
            4'hF:    seg = 7'b000_1110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // The bit leaving the top BCD nibble means the decimal value needs more digits than we have.
    assign adj_s        = add3(bcd_q);
    assign conv_carry_s = adj_s[BCD_W-1];
    assign conv_bcd_s   = {adj_s[BCD_W-2:0], shift_q[VALUE_W-1]};

    assign ext_s     = EXT_W'(shift_q);
    assign hex_ovf_s = |(ext_s >> BCD_W);
    assign digits_s  = dec_mode_q ? bcd_q : ext_s[BCD_W-1:0];
    assign ovf_s     = dec_mode_q ? sticky_q : hex_ovf_s;

    // Glyph selection for the pending display: dashes on overflow, else digits with optional blanking.
    always_comb begin : disp_comb
        logic seen_nz;
        seen_nz = 1'b0;
        segs_s  = {(7*NUM_DIGITS){1'b1}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digits_s[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end else begin
                seen_nz = seen_nz;
            end
            if (ovf_s) begin
                segs_s[7*i +: 7] = SEG_DASH;
            end else if (blank_lz_q && !seen_nz && (i != 0)) begin
                segs_s[7*i +: 7] = SEG_BLANK;
            end else begin
                segs_s[7*i +: 7] = glyph(digits_s[4*i +: 4]);
            end
        end
    end

    // Control FSM with registered display, status and conversion datapath.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            hex_segs   <= {(7*NUM_DIGITS){1'b1}};
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            dec_mode_q <= 1'b0;
            blank_lz_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        shift_q    <= value;
                        dec_mode_q <= dec_mode;
                        blank_lz_q <= blank_lz;
                        busy       <= 1'b1;
                        if (dec_mode) begin
                            bcd_q    <= '0;
                            sticky_q <= 1'b0;
                            cnt_q    <= CNT_W'(VALUE_W);
                            state_q  <= S_CONVERT;
                        end else begin
                            state_q  <= S_UPDATE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CONVERT: begin
                    bcd_q   <= conv_bcd_s;
                    shift_q <= {shift_q[VALUE_W-2:0], 1'b0};
                    if (conv_carry_s) begin
                        sticky_q <= 1'b1;
                    end else begin
                        sticky_q <= sticky_q;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_UPDATE;
                    end else begin
                        state_q <= S_CONVERT;
                    end
                end
                S_UPDATE: begin
                    hex_segs <= segs_s;
                    overflow <= ovf_s;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Directed, table-driven bench for score_display_driver (4-digit instance plus a 3-digit instance
// that exercises hex-mode overflow).
module tb_score_display_driver;

    localparam int VW      = 16;
    localparam int ND      = 4;
    localparam int ND2     = 3;
    localparam int LAT_HEX = 2;
    localparam int LAT_DEC = VW + 2;

    localparam logic [6:0] G0 = 7'b100_0000, G1 = 7'b111_1001, G2 = 7'b010_0100, G3 = 7'b011_0000;
    localparam logic [6:0] G4 = 7'b001_1001, G7 = 7'b111_1000, G9 = 7'b001_0000;
    localparam logic [6:0] GA = 7'b000_1000, GB = 7'b000_0011, GC = 7'b100_0110;
    localparam logic [6:0] GE = 7'b000_0110, GF = 7'b000_1110;
    localparam logic [6:0] BL = 7'b111_1111, DS = 7'b011_1111;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [VW-1:0]   value = '0;
    logic            load = 1'b0;
    logic            dec_mode = 1'b0;
    logic            blank_lz = 1'b0;
    logic [7*ND-1:0] hex_segs;
    logic            busy, done, overflow;
    logic [7*ND2-1:0] hex_segs2;
    logic            busy2, done2, overflow2;

    score_display_driver #(.VALUE_W(VW), .NUM_DIGITS(ND)) dut (
        .clk(clk), .resetn(resetn), .value(value), .load(load), .dec_mode(dec_mode),
        .blank_lz(blank_lz), .hex_segs(hex_segs), .busy(busy), .done(done), .overflow(overflow)
    );

    score_display_driver #(.VALUE_W(VW), .NUM_DIGITS(ND2)) dut2 (
        .clk(clk), .resetn(resetn), .value(value), .load(load), .dec_mode(dec_mode),
        .blank_lz(blank_lz), .hex_segs(hex_segs2), .busy(busy2), .done(done2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0]    value;
        logic             dec;
        logic             lz;
        logic [7*ND-1:0]  segs;
        logic             ovf;
        logic             chk2;
        logic [7*ND2-1:0] segs2;
        logic             ovf2;
    } vec_t;

    vec_t tv [12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses load for one cycle and returns the edge count until done (bounded).
    task automatic run_load(input logic [VW-1:0] v, input logic dm, input logic lz, output int lat);
        value    = v;
        dec_mode = dm;
        blank_lz = lz;
        load     = 1'b1;
        tick();
        load = 1'b0;
        lat  = 1;
        chk("busy_rise", 64'(busy), 64'(1));
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        tv[0]  = '{16'hBEEF, 1'b0, 1'b0, {GB, GE, GE, GF}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[1]  = '{16'h00A0, 1'b0, 1'b1, {BL, BL, GA, G0}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[2]  = '{16'd1234, 1'b1, 1'b0, {G1, G2, G3, G4}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[3]  = '{16'd7,    1'b1, 1'b1, {BL, BL, BL, G7}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[4]  = '{16'd0,    1'b1, 1'b1, {BL, BL, BL, G0}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[5]  = '{16'd12345, 1'b1, 1'b0, {DS, DS, DS, DS}, 1'b1, 1'b0, 21'h0, 1'b0};
        tv[6]  = '{16'd42,   1'b1, 1'b0, {G0, G0, G4, G2}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[7]  = '{16'd100,  1'b1, 1'b1, {BL, G1, G0, G0}, 1'b0, 1'b0, 21'h0, 1'b0};
        tv[8]  = '{16'h1ABC, 1'b0, 1'b0, {G1, GA, GB, GC}, 1'b0, 1'b1, {DS, DS, DS}, 1'b1};
        tv[9]  = '{16'h0ABC, 1'b0, 1'b1, {BL, GA, GB, GC}, 1'b0, 1'b1, {GA, GB, GC}, 1'b0};
        tv[10] = '{16'd65535, 1'b1, 1'b0, {DS, DS, DS, DS}, 1'b1, 1'b0, 21'h0, 1'b0};
        tv[11] = '{16'd9999, 1'b1, 1'b1, {G9, G9, G9, G9}, 1'b0, 1'b0, 21'h0, 1'b0};

        resetn = 1'b0;
        tick();
        tick();
        chk("reset_segs", 64'(hex_segs), 64'(28'hFFFFFFF));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_ovf", 64'(overflow), 64'(0));
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_load(tv[i].value, tv[i].dec, tv[i].lz, lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'(tv[i].dec ? LAT_DEC : LAT_HEX));
            chk($sformatf("segs[%0d]", i), 64'(hex_segs), 64'(tv[i].segs));
            chk($sformatf("ovf[%0d]", i), 64'(overflow), 64'(tv[i].ovf));
            chk($sformatf("busy_fall[%0d]", i), 64'(busy), 64'(0));
            if (tv[i].chk2) begin
                chk($sformatf("segs2[%0d]", i), 64'(hex_segs2), 64'(tv[i].segs2));
                chk($sformatf("ovf2[%0d]", i), 64'(overflow2), 64'(tv[i].ovf2));
            end
            tick();
            chk($sformatf("done_pulse[%0d]", i), 64'(done), 64'(0));
            chk($sformatf("segs_hold[%0d]", i), 64'(hex_segs), 64'(tv[i].segs));
        end

        // A load during conversion is ignored; a load in the done cycle is accepted.
        value = 16'd1234; dec_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        lat  = 1;
        repeat (3) begin tick(); lat++; end
        value = 16'd9999; load = 1'b1;
        tick();
        lat++;
        load = 1'b0;
        chk("busy_during_ignored", 64'(busy), 64'(1));
        chk("segs_no_intermediate", 64'(hex_segs), 64'({G9, G9, G9, G9}));
        while (!done && lat < 200) begin tick(); lat++; end
        chk("ignored_latency", 64'(lat), 64'(LAT_DEC));
        chk("ignored_segs", 64'(hex_segs), 64'({G1, G2, G3, G4}));
        run_load(16'd9999, 1'b1, 1'b0, lat);
        chk("done_cycle_latency", 64'(lat), 64'(LAT_DEC));
        chk("done_cycle_segs", 64'(hex_segs), 64'({G9, G9, G9, G9}));
        tick();

        // Reset in the middle of a conversion discards it.
        run_load(16'd12345, 1'b1, 1'b0, lat);
        chk("pre_reset_ovf", 64'(overflow), 64'(1));
        tick();
        value = 16'd1234; dec_mode = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        chk("conv_reset_segs", 64'(hex_segs), 64'(28'hFFFFFFF));
        chk("conv_reset_busy", 64'(busy), 64'(0));
        chk("conv_reset_done", 64'(done), 64'(0));
        chk("conv_reset_ovf", 64'(overflow), 64'(0));
        resetn = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (done) seen++;
        end
        chk("no_done_after_reset", 64'(seen), 64'(0));
        chk("segs_after_reset", 64'(hex_segs), 64'(28'hFFFFFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
